pix_word_packer: RTL and testbench

Downstream stage of the pixel FIFO. It pops 12-bit pixels from the FIFO's `q`/`qValid`/`qout` interface and packs them densely, LSB-first, into 16-bit words for the RAM writer. It uses a valid/ready output handshake. On an end-of-frame request it zero-pads and emits the final partial word, then pulses a completion flag.

---
 rtl/pix_word_packer.sv | 98 +++++++++
 tb/tb_pix_word_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pix_word_packer.sv
// rtl/pix_word_packer.sv - packs pixels LSB-first into words with end-of-frame flush
// Pixels enter a bit accumulator; words leave from its low end over a valid/ready handshake.
module pix_word_packer #(
  parameter int PixWidth   = 12,
  parameter int WordWidth  = 16,
  parameter int CountWidth = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PixWidth-1:0]   pix_d,
  input  logic                  pix_valid,
  output logic                  pix_pop,
  input  logic                  frame_end,
  output logic [WordWidth-1:0]  word_d,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [CountWidth-1:0] word_count,
  output logic                  flush_done
);

  localparam int AccWidth = PixWidth + WordWidth;
  localparam int CntBits  = $clog2(AccWidth + 1);
  localparam logic [CntBits-1:0] WordCnt = CntBits'(WordWidth);
  localparam logic [CntBits-1:0] PixCnt  = CntBits'(PixWidth);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state, state_n;
  logic [AccWidth-1:0] acc, acc_n, acc_sh, pix_ext;
  logic [CntBits-1:0]  cnt, cnt_n, cnt_sh;
  logic                xfer, valid_n;

  assign xfer    = word_valid & word_ready;
  assign acc_sh  = xfer ? (acc >> WordWidth) : acc;
  assign cnt_sh  = xfer ? (cnt - WordCnt) : cnt;
  assign pix_ext = {{WordWidth{1'b0}}, pix_d};
  // Pop only when the pixel fits after this cycle's word leaves; never from pix_d.
  assign pix_pop = (state == S_RUN) & pix_valid & (cnt_sh <= WordCnt) & ~rst;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    case (state)
      S_RUN: begin
        acc_n = pix_pop ? (acc_sh | (pix_ext << cnt_sh)) : acc_sh;
        cnt_n = pix_pop ? (cnt_sh + PixCnt) : cnt_sh;
        if (frame_end) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_n = S_DONE;
        end else if (xfer) begin
          if (cnt <= WordCnt) begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = S_DONE;
          end else begin
            acc_n = acc_sh;
            cnt_n = cnt_sh;
          end
        end
      end
      S_DONE:  state_n = S_RUN;
      default: state_n = S_RUN;
    endcase
    case (state_n)
      S_RUN:   valid_n = (cnt_n >= WordCnt);
      S_FLUSH: valid_n = (cnt_n != '0);
      default: valid_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      acc        <= '0;
      cnt        <= '0;
      word_count <= '0;
      word_valid <= 1'b0;
      word_d     <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      word_valid <= valid_n;
      word_d     <= acc_n[WordWidth-1:0];
      flush_done <= (state_n == S_DONE);
      // The frame total stays visible through DONE, then clears.
      if (state == S_DONE)
        word_count <= '0;
      else if (xfer && (word_count != {CountWidth{1'b1}}))
        word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pix_word_packer.sv
// tb/tb_pix_word_packer.sv - self-checking bench for pix_word_packer
module tb_pix_word_packer;

  localparam int PW = 12;
  localparam int WW = 16;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_d;
  logic          pix_valid;
  logic          pix_pop;
  logic          frame_end;
  logic [WW-1:0] word_d;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] word_count;
  logic          flush_done;

  pix_word_packer #(.PixWidth(PW), .WordWidth(WW), .CountWidth(CW)) dut (
    .clk(clk), .rst(rst), .pix_d(pix_d), .pix_valid(pix_valid), .pix_pop(pix_pop),
    .frame_end(frame_end), .word_d(word_d), .word_valid(word_valid),
    .word_ready(word_ready), .word_count(word_count), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic          pv;
    logic [PW-1:0] d;
    logic          rdy;
    logic          fe;
    logic          pop;
    logic          val;
    logic [WW-1:0] w;
    logic          done;
    logic [CW-1:0] wc;
  } vec_t;

  vec_t          tbl[$];
  logic [PW-1:0] pix_mem[0:1199];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [PW-1:0] d, input logic rdy, input logic fe,
                     input logic pop, input logic val, input logic [WW-1:0] w,
                     input logic done, input logic [CW-1:0] wc);
    vec_t v;
    v.pv = pv; v.d = d; v.rdy = rdy; v.fe = fe;
    v.pop = pop; v.val = val; v.w = w; v.done = done; v.wc = wc;
    tbl.push_back(v);
  endtask

  // Drives pix_mem[0:n-1] as a FIFO, optionally stalling and randomising, then flushes.
  task automatic run_stream(input int n, input int stall, input bit rnd, input string name,
                            output int pops_stall, output bit stable, output logic [WW-1:0] held);
    int            idx = 0;
    int            cyc = 0;
    int            nwords;
    logic [WW-1:0] words[$];
    bit            got_done = 1'b0;
    bit            fe_sent = 1'b0;
    bit            have_held = 1'b0;
    bit            underflow = 1'b0;
    logic [CW-1:0] final_cnt = '0;
    logic [WW-1:0] exp_w;
    nwords = (n * PW + WW - 1) / WW;
    pops_stall = 0;
    stable = 1'b1;
    held = '0;
    while (!got_done && cyc < 20000) begin
      frame_end = 1'b0;
      if (idx == n && !fe_sent) begin
        frame_end = 1'b1;
        fe_sent = 1'b1;
      end
      pix_valid  = (idx < n) && (cyc < stall || !rnd || $urandom_range(0, 3) != 0);
      pix_d      = pix_valid ? pix_mem[idx] : PW'($urandom);
      word_ready = (cyc >= stall) && (!rnd || $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (pix_pop && !pix_valid) underflow = 1'b1;
      if (cyc < stall) begin
        if (pix_pop) pops_stall++;
        if (word_valid) begin
          if (!have_held) begin
            held = word_d;
            have_held = 1'b1;
          end else if (word_d != held) begin
            stable = 1'b0;
          end
        end
      end
      if (word_valid && word_ready) words.push_back(word_d);
      if (flush_done) begin
        got_done = 1'b1;
        final_cnt = word_count;
      end
      if (pix_pop) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    frame_end = 1'b0; pix_valid = 1'b0; word_ready = 1'b0;
    check(got_done, {name, "_flush_done"}, 64'(got_done), 64'd1);
    check(!underflow, {name, "_underflow"}, 64'(underflow), 64'd0);
    check(words.size() == nwords, {name, "_nwords"}, 64'(words.size()), 64'(nwords));
    check(final_cnt == CW'(nwords), {name, "_word_count"}, 64'(final_cnt), 64'(nwords));
    for (int k = 0; k < nwords && k < words.size(); k++) begin
      for (int b = 0; b < WW; b++) begin
        int bit_i;
        bit_i = k * WW + b;
        exp_w[b] = (bit_i < n * PW) ? pix_mem[bit_i / PW][bit_i % PW] : 1'b0;
      end
      check(words[k] == exp_w, {name, "_word"}, 64'(words[k]), 64'(exp_w));
    end
  endtask

  initial begin
    int            pops;
    bit            stable;
    logic [WW-1:0] held;

    rst = 1'b1; pix_valid = 1'b1; pix_d = 12'hABC; frame_end = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    check(pix_pop == 1'b0, "reset_pop", 64'(pix_pop), 64'd0);
    check(word_valid == 1'b0 && word_d == '0 && flush_done == 1'b0 && word_count == '0,
          "reset_outputs", {word_valid, word_d, flush_done, word_count}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; pix_valid = 1'b0;

    // pack order, empty flush, partial flush
    add(1'b1, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 20'd0);
    add(1'b1, 12'hDEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC, 1'b0, 20'd0);
    add(1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFABC, 1'b0, 20'd0);
    add(1'b1, 12'h456, 1'b1, 1'b0, 1'b1, 1'b1, 16'h23DE, 1'b0, 20'd1);
    add(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4561, 1'b0, 20'd2);
    add(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 20'd3);
    add(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 20'd3);
    add(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 20'd3);
    add(1'b1, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 20'd0);
    add(1'b1, 12'hDEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC, 1'b0, 20'd0);
    add(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFABC, 1'b0, 20'd0);
    add(1'b1, 12'h555, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00DE, 1'b0, 20'd1);
    add(1'b1, 12'h555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 20'd2);
    add(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 20'd0);

    foreach (tbl[i]) begin
      pix_valid = tbl[i].pv; pix_d = tbl[i].d; word_ready = tbl[i].rdy; frame_end = tbl[i].fe;
      @(negedge clk);
      vecs++;
      if (pix_pop !== tbl[i].pop || word_valid !== tbl[i].val || word_d !== tbl[i].w ||
          flush_done !== tbl[i].done || word_count !== tbl[i].wc) begin
        errs++;
        $display("FAIL vec%0d: got pop=%b val=%b w=%h done=%b wc=%0d expected pop=%b val=%b w=%h done=%b wc=%0d",
                 i, pix_pop, word_valid, word_d, flush_done, word_count,
                 tbl[i].pop, tbl[i].val, tbl[i].w, tbl[i].done, tbl[i].wc);
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0; frame_end = 1'b0;

    // backpressure: 10 stalled cycles with the FIFO always valid
    pix_mem[0] = 12'hABC; pix_mem[1] = 12'hDEF; pix_mem[2] = 12'h123; pix_mem[3] = 12'h456;
    run_stream(4, 10, 1'b0, "stall", pops, stable, held);
    check(pops == 2, "stall_pops", 64'(pops), 64'd2);
    check(stable, "stall_stable", 64'(stable), 64'd1);
    check(held == 16'hFABC, "stall_word", 64'(held), 64'hFABC);

    // sustained random stream: 1200 pixels -> 900 words
    for (int i = 0; i < 1200; i++) pix_mem[i] = PW'($urandom);
    run_stream(1200, 0, 1'b1, "stream", pops, stable, held);

    // async reset mid-frame with cnt = 20
    word_ready = 1'b1; pix_valid = 1'b1; pix_d = 12'hABC;
    @(posedge clk); #1; pix_d = 12'hDEF;
    @(posedge clk); #1; pix_d = 12'h123;
    @(posedge clk); #1; pix_valid = 1'b0;
    @(negedge clk);
    check(word_valid && word_d == 16'h23DE, "prereset_word", {word_valid, word_d}, {1'b1, 16'h23DE});
    #2;
    pix_valid = 1'b1; pix_d = 12'h111; rst = 1'b1;
    #1;
    check(word_valid == 1'b0 && pix_pop == 1'b0, "async_rst_outputs", {word_valid, pix_pop}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; pix_d = 12'h7A5; pix_valid = 1'b1;
    @(negedge clk);
    check(pix_pop == 1'b1, "post_rst_pop", 64'(pix_pop), 64'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check(word_d[11:0] == 12'h7A5 && !word_valid && word_count == '0, "post_rst_word",
          {word_valid, word_count, word_d}, {1'b0, 20'd0, 16'h07A5});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
